// File: rtl/exe_stage.sv
// Execute stage: barrel-shifted operand, NZCV ALU, and branch target adder.
// Define MUL_UNIT_EN to add the 33-cycle shift-add multiplier on EXE_CMD 1010.
module exe_stage #(
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [3:0]  EXE_CMD,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] imm24,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  output logic [31:0] ALU_Res,
  output logic [31:0] Br_addr,
  output logic [3:0]  status,
  output logic        mul_stall
);

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input logic [4:0]  r
  );
    return (x >> r) | (x << (5'd0 - r));
  endfunction

  logic [31:0] val2;
  logic [4:0]  sh_amt;
  logic [4:0]  rot_amt;

  assign sh_amt  = Shift_operand[11:7];
  assign rot_amt = {Shift_operand[11:8], 1'b0};

  always_comb begin
    val2 = '0;
    if (MEM_R_EN | MEM_W_EN) begin
      val2 = {20'b0, Shift_operand};
    end else if (imm) begin
      val2 = ror({24'b0, Shift_operand[7:0]}, rot_amt);
    end else begin
      unique case (Shift_operand[6:5])
        2'b00: val2 = Val_Rm << sh_amt;
        2'b01: val2 = Val_Rm >> sh_amt;
        2'b10: val2 = $signed(Val_Rm) >>> sh_amt;
        2'b11: val2 = ror(Val_Rm, sh_amt);
      endcase
    end
  end

  logic        mul_done;
  logic [31:0] prod;

`ifdef MUL_UNIT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        is_mul;

  assign is_mul    = EXE_CMD == 4'b1010;
  assign mul_done  = state == DONE;
  assign mul_stall = rst & ((state == IDLE & is_mul) | state == BUSY);

  // One multiplier bit per cycle; multiplicand walks left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      unique case (state)
        IDLE: if (is_mul) begin
          state  <= BUSY;
          cnt    <= '0;
          prod   <= '0;
          mcand  <= val2;
          mplier <= Val_Rn;
        end
        BUSY: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign mul_done  = 1'b0;
  assign prod      = '0;
  assign mul_stall = 1'b0;
`endif

  logic [31:0] op_b;
  logic        cin;
  logic [32:0] sum;
  logic        add_v;

  // SUB/SBC reuse the adder with an inverted operand.
  always_comb begin
    op_b = val2;
    cin  = 1'b0;
    unique case (EXE_CMD)
      4'b0011: cin = status[1];
      4'b0100: begin op_b = ~val2; cin = 1'b1; end
      4'b0101: begin op_b = ~val2; cin = status[1]; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, Val_Rn} + {1'b0, op_b} + {32'b0, cin};
  assign add_v = (Val_Rn[31] == op_b[31]) & (sum[31] != Val_Rn[31]);

  logic [31:0] res;
  logic        arith;
  logic [3:0]  nzcv;

  always_comb begin
    res   = '0;
    arith = 1'b0;
    unique case (EXE_CMD)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        res   = sum[31:0];
        arith = 1'b1;
      end
      4'b0110: res = Val_Rn & val2;
      4'b0111: res = Val_Rn | val2;
      4'b1000: res = Val_Rn ^ val2;
      default: res = '0;
    endcase
    if (mul_done) begin
      res   = prod;
      arith = 1'b0;
    end
  end

  assign nzcv = {res[31], res == 32'b0,
                 arith ? sum[32] : status[1],
                 arith ? add_v : status[0]};

  assign ALU_Res = res;
  assign Br_addr = PC + {{6{imm24[23]}}, imm24, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status <= STATUS_RST;
    else if (S && !mul_stall) status <= nzcv;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter STATUS_RST, default 4'b0000: NZCV status register value loaded at reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port PC  input  32  PC+4 of the instruction in EXE.
REQ-005 SHALL have port EXE_CMD  input  4  ALU operation code.
REQ-006 SHALL have ports MEM_R_EN and MEM_W_EN  input  1 each  load / store instruction flags.
REQ-007 SHALL have port S  input  1  update-status request.
REQ-008 SHALL have port imm  input  1  immediate-operand flag.
REQ-009 SHALL have port Shift_operand  input  12  immediate or shift field.
REQ-010 SHALL have port imm24  input  24  signed branch offset, in words.
REQ-011 SHALL have ports Val_Rn and Val_Rm  input  32 each  register operands.
REQ-012 SHALL have port ALU_Res  output  32  ALU result, or memory address for loads and stores.
REQ-013 SHALL have port Br_addr  output  32  branch target.
REQ-014 SHALL have port status  output  4  registered {N,Z,C,V}; status[1] also feeds the ID stage carry input.
REQ-015 SHALL have port mul_stall  output  1  freeze request to PC, IF/ID, ID/EX and EX/MEM registers.

Function
REQ-016 Val2 SHALL be selected in this priority order:
- MEM_R_EN|MEM_W_EN: zero-extended Shift_operand.
- imm=1: Shift_operand[7:0] rotated right by 2*Shift_operand[11:8].
- otherwise: Val_Rm shifted by Shift_operand[11:7] using Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-017 EXE_CMD map SHALL be:
- 0001 MOV=Val2; 1001 MVN=~Val2.
- 0010 ADD; 0011 ADC=Rn+Val2+C; 0100 SUB; 0101 SBC=Rn+~Val2+C.
- 0110 AND; 0111 ORR; 1000 EOR.
- All other codes: ALU_Res=0.
REQ-018 N and Z SHALL derive from the 32-bit result; C is the carry-out, with SUB computed as Rn+~Val2+1; V is two's-complement overflow. Logical and move ops SHALL leave C and V unchanged.
REQ-019 Br_addr SHALL equal PC + (sign-extended imm24 << 2), modulo 2^32, combinationally.
REQ-020 status SHALL load the new NZCV on a rising edge only when S=1 and mul_stall=0; otherwise it holds.
REQ-021 ALU outputs other than the multiply path SHALL be combinational, zero latency.

Reset
REQ-022 While rst=0, asynchronously: status=STATUS_RST; FSM=IDLE; counter=0; product and multiplicand registers=0; mul_stall=0.
REQ-023 Reset asserted mid-multiply SHALL abort it; after release the ID/EX instruction is re-evaluated from IDLE.

Configuration
REQ-024 Macro MUL_UNIT_EN defined SHALL compile in a shift-add multiplier decoded on EXE_CMD 1010.
- FSM states: IDLE -> BUSY (32 iterations, 5-bit counter 0..31, one multiplier bit per cycle) -> DONE (1 cycle) -> IDLE.
- mul_stall = (IDLE & EXE_CMD==1010) | BUSY.
- In DONE: ALU_Res = low 32 bits of Rn*Val2; mul_stall=0; if S=1, N and Z update and C, V hold.
- Result appears 33 cycles after the MUL enters EXE.
REQ-025 Macro MUL_UNIT_EN undefined: no FSM; code 1010 behaves per the default row of REQ-017; mul_stall is tied to 0.
REQ-026 Wrap-around SHALL be modulo 2^32 for all arithmetic, including the multiply product.

Verification
REQ-027 ADD with S=1, Rn=0x7FFFFFFF, Val2=1 (imm=1, Shift_operand=0x001) -> ALU_Res 0x80000000; status 1001 after the edge.
REQ-028 SUB, S=1, Rn=5, Val_Rm=5, LSL #0 -> ALU_Res 0; status 0110. Same op with S=0 -> status unchanged.
REQ-029 Register-shift operands:
- Val_Rm=0x80000001, ASR #1 -> Val2 0xC0000000.
- imm=1, Shift_operand=0x4FF -> Val2 0xFF000000.
REQ-030 PC=0x100, imm24=0xFFFFFE -> Br_addr 0xF8. imm24=0x000001 -> Br_addr 0x104.
REQ-031 With MUL_UNIT_EN: Rn=0x10000, Val_Rm=0x30001, S=1 -> mul_stall high for cycles 0..32; cycle 33 ALU_Res 0x10000, stall low. rst pulsed at cycle 10 -> FSM restarts from IDLE.
REQ-032 Without MUL_UNIT_EN: EXE_CMD 1010 -> ALU_Res 0; mul_stall stays 0.
